// File: rtl/pwm_compare.sv
// Shadowed-threshold compare stage driving a complementary PWM pair with dead-time.
// All outputs registered; compare/raw level lag value by one cycle, drive by two; no backpressure.
module pwm_compare #(
  parameter int bitwidth        = 8,
  parameter int deadtime_width  = 4,
  parameter int invert_polarity = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      counting,
  input  logic [bitwidth-1:0]       value,
  input  logic                      overflow,
  input  logic [bitwidth-1:0]       compare_value,
  input  logic [deadtime_width-1:0] deadtime,
  output logic [bitwidth-1:0]       active_compare_value,
  output logic                      update,
  output logic                      compare_match,
  output logic                      pwm_high,
  output logic                      pwm_low
);

  localparam logic pol_inv = (invert_polarity != 0);

  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    LOW,
    DEAD_TO_HIGH,
    DEAD_TO_LOW
  } state_t;

  state_t                    state, state_next;
  logic [deadtime_width-1:0] dt_cnt, dt_cnt_next;
  logic                      overflow_d;
  logic                      raw_q;
  logic                      match_armed;
  logic                      overflow_rise;
  logic                      update_event;
  logic                      match_hit;
  logic                      start;
  logic                      start_high;

  assign overflow_rise = overflow & ~overflow_d;
  assign update_event  = overflow_rise | ~counting;
  assign match_hit     = counting & match_armed & (value == active_compare_value)
                         & (active_compare_value != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_d           <= 1'b0;
      update               <= 1'b0;
      active_compare_value <= '0;
      raw_q                <= 1'b0;
      compare_match        <= 1'b0;
      match_armed          <= 1'b0;
    end else begin
      overflow_d    <= overflow;
      update        <= overflow_rise;
      raw_q         <= counting & (value < active_compare_value);
      compare_match <= match_hit;
      if (update_event) begin
        active_compare_value <= compare_value;
      end
      // A new period re-arms even if the old period's match lands on the same cycle.
      if (update_event) begin
        match_armed <= 1'b1;
      end else if (match_hit) begin
        match_armed <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next  = state;
    dt_cnt_next = dt_cnt;
    start       = 1'b0;
    start_high  = 1'b0;
    if (!enable) begin
      state_next  = IDLE;
      dt_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          start      = 1'b1;
          start_high = raw_q;
        end
        HIGH: begin
          if (!raw_q) begin
            start      = 1'b1;
            start_high = 1'b0;
          end
        end
        LOW: begin
          if (raw_q) begin
            start      = 1'b1;
            start_high = 1'b1;
          end
        end
        DEAD_TO_HIGH, DEAD_TO_LOW: begin
          // The dead interval always runs out; the exit side follows raw_q at expiry.
          if (dt_cnt <= deadtime_width'(1)) begin
            state_next  = raw_q ? HIGH : LOW;
            dt_cnt_next = '0;
          end else begin
            dt_cnt_next = dt_cnt - 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
      if (start) begin
        if (deadtime == '0) begin
          state_next = start_high ? HIGH : LOW;
        end else begin
          state_next  = start_high ? DEAD_TO_HIGH : DEAD_TO_LOW;
          dt_cnt_next = deadtime;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      dt_cnt   <= '0;
      pwm_high <= pol_inv;
      pwm_low  <= pol_inv;
    end else begin
      state    <= state_next;
      dt_cnt   <= dt_cnt_next;
      pwm_high <= pol_inv ^ (state_next == HIGH);
      pwm_low  <= pol_inv ^ (state_next == LOW);
    end
  end

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare: drives a modulo-10 up-counter model and checks PWM behaviour.
module tb_pwm_compare;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       counting;
  logic [7:0] value;
  logic       overflow;
  logic [7:0] compare_value;
  logic [3:0] deadtime;

  logic [7:0] acv, acv_i;
  logic       update, update_i;
  logic       compare_match, match_i;
  logic       pwm_high, pwm_low, pwm_high_i, pwm_low_i;

  int errors = 0;
  int checks = 0;

  logic       run;
  logic       hold;
  logic [7:0] cnt;
  localparam logic [7:0] reload = 8'd9;

  typedef struct {
    logic [7:0] cv;
    logic [3:0] dt;
    int hi;
    int lo;
    int off;
    int mt;
    int up;
  } vec_t;
  vec_t vecs[7];

  int hi, lo, off, both, mt, up, inv_bad, bad, g;
  logic prev_low, found;

  pwm_compare #(.bitwidth(8), .deadtime_width(4), .invert_polarity(0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .counting(counting),
    .value(value), .overflow(overflow), .compare_value(compare_value),
    .deadtime(deadtime), .active_compare_value(acv), .update(update),
    .compare_match(compare_match), .pwm_high(pwm_high), .pwm_low(pwm_low)
  );

  pwm_compare #(.bitwidth(8), .deadtime_width(4), .invert_polarity(1)) dut_inv (
    .clock(clock), .reset(reset), .enable(enable), .counting(counting),
    .value(value), .overflow(overflow), .compare_value(compare_value),
    .deadtime(deadtime), .active_compare_value(acv_i), .update(update_i),
    .compare_match(match_i), .pwm_high(pwm_high_i), .pwm_low(pwm_low_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock, then drive the upstream counter outputs for the new cycle.
  task automatic step();
    @(posedge clock);
    #1;
    if (run && !hold) cnt = (cnt == reload) ? 8'd0 : cnt + 8'd1;
    counting = run;
    value    = cnt;
    overflow = run && (cnt == reload);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd3,   4'd2, 3,  15, 12, 3, 3};
    vecs[1] = '{8'd5,   4'd1, 12, 12, 6,  3, 3};
    vecs[2] = '{8'd0,   4'd2, 0,  30, 0,  0, 3};
    vecs[3] = '{8'd200, 4'd2, 30, 0,  0,  0, 3};
    vecs[4] = '{8'd3,   4'd0, 9,  21, 0,  3, 3};
    vecs[5] = '{8'd7,   4'd3, 21, 0,  9,  3, 3};
    vecs[6] = '{8'd3,   4'd5, 0,  15, 15, 3, 3};

    // Reset held with random inputs
    reset = 1'b0; run = 1'b0; hold = 1'b0; cnt = 8'd0;
    enable = 1'b0; counting = 1'b0; value = 8'd0; overflow = 1'b0;
    compare_value = 8'd0; deadtime = 4'd0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      enable        = 1'($urandom_range(0, 1));
      counting      = 1'($urandom_range(0, 1));
      overflow      = 1'($urandom_range(0, 1));
      value         = 8'($urandom);
      compare_value = 8'($urandom);
      deadtime      = 4'($urandom);
      if (acv !== 8'd0 || update !== 1'b0 || compare_match !== 1'b0 ||
          pwm_high !== 1'b0 || pwm_low !== 1'b0 ||
          pwm_high_i !== 1'b1 || pwm_low_i !== 1'b1) bad++;
    end
    check("reset_hold_values", bad, 0);
    check("reset_pwm_high", int'(pwm_high), 0);
    check("reset_pwm_high_inv", int'(pwm_high_i), 1);

    // Release with enable low: outputs must stay idle
    enable = 1'b0; counting = 1'b0; value = 8'd0; overflow = 1'b0;
    compare_value = 8'd0; deadtime = 4'd2;
    #2 reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (pwm_high !== 1'b0 || pwm_low !== 1'b0 || pwm_high_i !== 1'b1 ||
          pwm_low_i !== 1'b1 || update !== 1'b0 || compare_match !== 1'b0) bad++;
    end
    check("idle_after_release", bad, 0);

    // Steady-state vectors, 3 periods measured each
    enable = 1'b1; run = 1'b1;
    for (int v = 0; v < 7; v++) begin
      compare_value = vecs[v].cv;
      deadtime      = vecs[v].dt;
      repeat (30) step();
      hi = 0; lo = 0; off = 0; both = 0; mt = 0; up = 0; inv_bad = 0;
      for (int c = 0; c < 30; c++) begin
        step();
        hi += int'(pwm_high);
        lo += int'(pwm_low);
        if (!pwm_high && !pwm_low) off++;
        if (pwm_high && pwm_low) both++;
        mt += int'(compare_match);
        up += int'(update);
        if (pwm_high_i !== ~pwm_high || pwm_low_i !== ~pwm_low) inv_bad++;
      end
      check($sformatf("v%0d_high_cycles", v), hi, vecs[v].hi);
      check($sformatf("v%0d_low_cycles", v), lo, vecs[v].lo);
      check($sformatf("v%0d_off_cycles", v), off, vecs[v].off);
      check($sformatf("v%0d_both_on", v), both, 0);
      check($sformatf("v%0d_matches", v), mt, vecs[v].mt);
      check($sformatf("v%0d_updates", v), up, vecs[v].up);
      check($sformatf("v%0d_inverted_pair", v), inv_bad, 0);
    end

    // Shadowing: threshold change mid-period takes effect next period
    compare_value = 8'd3; deadtime = 4'd2;
    repeat (30) step();
    for (int i = 0; i < 20 && value != 8'd4; i++) step();
    compare_value = 8'd7;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (value == 8'd0) break;
      if (acv !== 8'd3 || update !== 1'b0) bad++;
    end
    check("shadow_old_threshold", bad, 0);
    check("shadow_new_threshold", int'(acv), 7);
    check("shadow_update_pulse", int'(update), 1);
    step();
    check("shadow_update_one_cycle", int'(update), 0);
    mt = 0; up = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      mt += int'(compare_match);
      up += int'(update);
    end
    check("shadow_next_matches", mt, 1);
    check("shadow_next_updates", up, 1);

    // Counter stuck on the threshold: single match only
    compare_value = 8'd3;
    repeat (12) step();
    for (int i = 0; i < 20 && value != 8'd3; i++) step();
    hold = 1'b1;
    mt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      mt += int'(compare_match);
    end
    hold = 1'b0;
    check("stuck_value_matches", mt, 1);

    // 5-cycle dead interval with raw_q falling back before it expires
    compare_value = 8'd3; deadtime = 4'd5;
    repeat (25) step();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      prev_low = pwm_low;
      step();
      if (prev_low && !pwm_low) begin
        found = 1'b1;
        break;
      end
    end
    check("dead5_entered", int'(found), 1);
    g = 0;
    while (!pwm_high && !pwm_low && g < 20) begin
      g++;
      step();
    end
    check("dead5_gap_length", g, 5);
    check("dead5_ends_low", int'(pwm_low), 1);
    check("dead5_not_high", int'(pwm_high), 0);

    // Enable drop from HIGH, then re-entry through a full dead interval
    compare_value = 8'd200; deadtime = 4'd2;
    repeat (25) step();
    check("en_pre_high", int'(pwm_high), 1);
    enable = 1'b0;
    step();
    check("en_drop_high_off", int'(pwm_high), 0);
    check("en_drop_low_off", int'(pwm_low), 0);
    enable = 1'b1;
    step(); hi = int'(pwm_high) + int'(pwm_low);
    step(); hi += int'(pwm_high) + int'(pwm_low);
    check("en_reentry_dead_off", hi, 0);
    step();
    check("en_reentry_high", int'(pwm_high), 1);

    // Enable drop mid-dead clears the counter; next dead interval is full length
    enable = 1'b0; step();
    deadtime = 4'd3; enable = 1'b1; step();
    enable = 1'b0; step();
    check("en_mid_dead_idle", int'(pwm_high) + int'(pwm_low), 0);
    enable = 1'b1;
    step();
    g = 0;
    while (!pwm_high && !pwm_low && g < 20) begin
      g++;
      step();
    end
    check("en_after_mid_dead_gap", g, 3);
    check("en_after_mid_dead_high", int'(pwm_high), 1);

    // Asynchronous reset in the middle of a dead interval
    enable = 1'b0; step();
    deadtime = 4'd5; enable = 1'b1;
    step(); step();
    #2 reset = 1'b0;
    #1;
    check("areset_dead_acv", int'(acv), 0);
    check("areset_dead_pwm", int'(pwm_high) + int'(pwm_low), 0);
    check("areset_dead_inv_pwm", int'(pwm_high_i) + int'(pwm_low_i), 2);
    #1 reset = 1'b1;
    mt = 0;
    for (int i = 0; i < 12 && update !== 1'b1; i++) begin
      step();
      mt += int'(compare_match);
    end
    check("areset_first_update", int'(update), 1);
    check("areset_acv_reloaded", int'(acv), 200);
    check("areset_no_early_match", mt, 0);

    // Asynchronous reset while driving HIGH
    repeat (30) step();
    check("areset_pre_high", int'(pwm_high), 1);
    check("areset_pre_high_inv", int'(pwm_high_i), 0);
    #2 reset = 1'b0;
    #1;
    check("areset_high_dropped", int'(pwm_high), 0);
    check("areset_high_inv_rest", int'(pwm_high_i), 1);
    #1 reset = 1'b1;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
